vga_hsync_gen: RTL and testbench
================================

Name: vga_hsync_gen

Overview:
Horizontal timing generator that sits directly upstream of the vertical-sync/colour stage in the VGA system. It runs on the 100 MHz board clock and derives a pixel-rate strobe (25 MHz at the default divide of 4). It walks each 640x480@60 scan line through display, front porch, sync and back porch. It supplies the vertical stage with h_sync, active-video, column and an end-of-line pulse, which the vertical stage uses as its line-increment enable.

Parameters:
CLK_DIV, 4, board clocks per pixel; legal range 1..16.
H_VISIBLE, 640, active pixels per line.
H_FP, 16, front-porch pixels.
H_SYNC, 96, sync-pulse pixels.
H_BP, 48, back-porch pixels.
H_SYNC_POL, 0, asserted level of h_sync; 0 means active-low.

Ports:
clk  input  1  board clock, 100 MHz
reset  input  1  asynchronous, active-low reset
pix_en  output  1  one-clk strobe at pixel rate; all other outputs are valid while it is high
h_sync  output  1  horizontal sync at H_SYNC_POL polarity
h_active  output  1  1 while in the visible region
h_col  output  10  visible column 0..H_VISIBLE-1; 0 outside the visible region
h_count  output  10  raw line position 0..H_TOTAL-1, where H_TOTAL = sum of the four segments
line_end  output  1  one-clk pulse coincident with pix_en on the last pixel of a line

Behaviour:
- Reset (reset=0, asynchronous):
  - pix_en=0, line_end=0, h_count=0, h_col=0.
  - h_active=1, h_sync=!H_SYNC_POL.
  - FSM in H_DISP, divider count=0.
- Divider:
  - 2..4-bit count increments every clk and wraps at CLK_DIV-1.
  - pix_en is registered and high for exactly 1 clk every CLK_DIV clks.
  - First pix_en occurs in the CLK_DIV-th clk after reset release.
  - CLK_DIV=1 holds pix_en constantly high.
- Advance rule:
  - Position state (FSM, segment counter, h_count) changes only on the clk edge that ends a pix_en cycle.
  - All outputs are registered and stable between strobes.
  - Output values seen with pix_en=1 describe the current pixel.
- FSM states: H_DISP -> H_FP -> H_SYNC -> H_BP -> H_DISP.
  - A per-segment down-counter is loaded with (segment length - 1) on entry.
  - The state transitions on the strobe where the counter reaches 0.
  - The line starts at H_DISP with h_count=0.
  - h_count increments per strobe and wraps from H_TOTAL-1 to 0 together with the H_BP -> H_DISP transition.
- Default segment boundaries (h_count values):
  - H_DISP 0..639
  - H_FP 640..655
  - H_SYNC 656..751
  - H_BP 752..799
- Segment outputs:
  - h_active=1 only in H_DISP.
  - h_col=h_count in H_DISP, 0 elsewhere.
  - h_sync=H_SYNC_POL only in H_SYNC.
- line_end:
  - High when pix_en=1 and h_count=H_TOTAL-1.
  - Exactly one pulse per H_TOTAL strobes.
  - Never high when pix_en=0.
- Widths:
  - h_count and h_col are 10 bits; H_TOTAL must be at most 1024.
  - Any parameter set with a segment length of 0 is illegal; an elaboration-time check flags it.
- Reset mid-line: all state returns asynchronously to the reset values, and the next line restarts from h_count=0 with no partial line_end.
- No other inputs: free-running, no stall or enable.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 horizontal and vertical constants.
  - H_TOTAL derivation.
  - FSM state typedef/encoding (2 bits: H_DISP=0, H_FP=1, H_SYNC=2, H_BP=3).
  - The same package is shared with the vertical stage.
- One sub-module: vga_pix_div, the CLK_DIV clock-enable divider producing pix_en.
- The FSM and counters live in vga_hsync_gen.

Test Plan:
- Reset: hold reset=0 for 5 clks, then release. During reset: h_sync=1, h_count=0, pix_en=0, line_end=0. First pix_en at clk 4 after release, with h_count=0, h_active=1.
- Strobe period: over 40 clks, pix_en is high exactly 10 times, each 1 clk wide, spaced 4 clks apart. Outputs do not change on non-strobe clks.
- Full line: count strobes. h_active=1 for h_count 0..639 with h_col matching. h_sync=0 for h_count 656..751 (96 strobes). line_end once at h_count=799. The next strobe shows h_count=0. Line length is 3200 clks.
- Multi-line: run 3 lines. Exactly 3 line_end pulses, 3200 clks apart. h_sync falling edges are 3200 clks apart.
- Mid-line reset: assert reset at h_count=700 (in sync). h_sync goes to 1 immediately, without waiting for clk. After release, the line restarts at h_count=0 and no line_end appears before h_count=799.
- Config CLK_DIV=1, H_SYNC_POL=1: pix_en is constantly 1 and a line is 800 clks. h_sync is high for h_count 656..751 and low otherwise.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 timing constants for the horizontal and vertical stages,
// the segment-total helper and the horizontal FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixels.
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;

    // Vertical timing, in lines.
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    // Total period of a display / porch / sync / porch sequence.
    function automatic int seg_total(input int vis, input int fp,
                                     input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = seg_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = seg_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // Horizontal segment FSM encoding.
    typedef enum logic [1:0] {
        H_DISP = 2'd0,
        H_FP   = 2'd1,
        H_SYNC = 2'd2,
        H_BP   = 2'd3
    } h_state_t;

endpackage

// File: rtl/vga_pix_div.sv
// -----------------------------------------------------------------------------
// vga_pix_div
// Clock-enable divider: produces a one-clk pixel strobe every CLK_DIV clks.
// Ports:
//   clk      board clock
//   reset    asynchronous active-low reset
//   pix_tick combinational: the next clk edge raises pix_en
//   pix_en   registered strobe, high for 1 clk every CLK_DIV clks
//            (constantly high when CLK_DIV = 1)
// -----------------------------------------------------------------------------
module vga_pix_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 4) ? 4 : 2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_pix_div: CLK_DIV must be in 1..16");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;

    // The strobe is registered off the wrap condition, so the first pix_en
    // lands in the CLK_DIV-th clk after reset release.
    assign pix_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
            pix_en  <= pix_tick;
        end
    end

endmodule

// File: rtl/vga_hsync_gen.sv
// -----------------------------------------------------------------------------
// vga_hsync_gen
// Horizontal timing generator: walks each scan line through display, front
// porch, sync and back porch at the pixel-strobe rate. Free running; there is
// no handshake, so consumers simply qualify every output with pix_en.
// Ports:
//   clk      board clock (100 MHz)
//   reset    asynchronous active-low reset
//   pix_en   one-clk pixel strobe; other outputs describe the current pixel
//            while it is high
//   h_sync   horizontal sync at H_SYNC_POL polarity
//   h_active 1 in the visible region
//   h_col    visible column, 0 outside the visible region
//   h_count  raw line position 0..H_TOTAL-1
//   line_end pulse with pix_en on the last pixel of a line
//   h_state  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module vga_hsync_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = vga_timing_pkg::VGA_H_VISIBLE,
    parameter int H_FP       = vga_timing_pkg::VGA_H_FP,
    parameter int H_SYNC     = vga_timing_pkg::VGA_H_SYNC,
    parameter int H_BP       = vga_timing_pkg::VGA_H_BP,
    parameter bit H_SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic       h_sync,
    output logic       h_active,
    output logic [9:0] h_col,
    output logic [9:0] h_count,
    output logic       line_end,
    output logic [1:0] h_state
);

    import vga_timing_pkg::*;

    localparam int H_TOTAL = seg_total(H_VISIBLE, H_FP, H_SYNC, H_BP);

    generate
        if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || H_TOTAL > 1024)
        begin : g_bad_timing
            $error("vga_hsync_gen: segment lengths must be >= 1 and H_TOTAL <= 1024");
        end
    endgenerate

    localparam logic [9:0] DISP_LAST  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] FP_LAST    = 10'(H_FP - 1);
    localparam logic [9:0] SYNC_LAST  = 10'(H_SYNC - 1);
    localparam logic [9:0] BP_LAST    = 10'(H_BP - 1);
    localparam logic [9:0] TOTAL_LAST = 10'(H_TOTAL - 1);

    logic       pix_tick;
    h_state_t   state, state_nxt;
    logic [9:0] seg_cnt, seg_nxt;
    logic [9:0] cnt_nxt;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick),
        .pix_en   (pix_en)
    );

    assign h_state = state;

    // Position advances on the edge that ends a pix_en cycle. The *_nxt values
    // are therefore the position seen during the following clk, which is what
    // all the registered outputs are decoded from.
    always_comb begin
        state_nxt = state;
        seg_nxt   = seg_cnt;
        cnt_nxt   = h_count;
        if (pix_en) begin
            cnt_nxt = (state == vga_timing_pkg::H_BP && seg_cnt == '0) ? '0 : h_count + 10'd1;
            if (seg_cnt == '0) begin
                case (state)
                    vga_timing_pkg::H_DISP: begin
                        state_nxt = vga_timing_pkg::H_FP;
                        seg_nxt   = FP_LAST;
                    end
                    vga_timing_pkg::H_FP: begin
                        state_nxt = vga_timing_pkg::H_SYNC;
                        seg_nxt   = SYNC_LAST;
                    end
                    vga_timing_pkg::H_SYNC: begin
                        state_nxt = vga_timing_pkg::H_BP;
                        seg_nxt   = BP_LAST;
                    end
                    default: begin
                        state_nxt = vga_timing_pkg::H_DISP;
                        seg_nxt   = DISP_LAST;
                    end
                endcase
            end else begin
                seg_nxt = seg_cnt - 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= vga_timing_pkg::H_DISP;
            seg_cnt  <= DISP_LAST;
            h_count  <= '0;
            h_active <= 1'b1;
            h_sync   <= ~H_SYNC_POL;
            h_col    <= '0;
            line_end <= 1'b0;
        end else begin
            state    <= state_nxt;
            seg_cnt  <= seg_nxt;
            h_count  <= cnt_nxt;
            h_active <= (state_nxt == vga_timing_pkg::H_DISP);
            h_sync   <= (state_nxt == vga_timing_pkg::H_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            h_col    <= (state_nxt == vga_timing_pkg::H_DISP) ? cnt_nxt : '0;
            // pix_tick raises pix_en on this same edge, so the pulse is
            // coincident with the strobe of the last pixel.
            line_end <= pix_tick && (cnt_nxt == TOTAL_LAST);
        end
    end

endmodule

// File: tb/tb_vga_hsync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_hsync_gen
// Directed bench for vga_hsync_gen: default 640x480 instance plus a
// CLK_DIV=1 / active-high-sync instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_vga_hsync_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       pix_en0, h_sync0, h_active0, line_end0;
    logic [9:0] h_col0, h_count0;
    logic [1:0] h_state0;
    logic       pix_en1, h_sync1, h_active1, line_end1;
    logic [9:0] h_col1, h_count1;
    logic [1:0] h_state1;

    vga_hsync_gen dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en0), .h_sync(h_sync0),
        .h_active(h_active0), .h_col(h_col0), .h_count(h_count0),
        .line_end(line_end0), .h_state(h_state0)
    );

    vga_hsync_gen #(.CLK_DIV(1), .H_SYNC_POL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en1), .h_sync(h_sync1),
        .h_active(h_active1), .h_col(h_col1), .h_count(h_count1),
        .line_end(line_end1), .h_state(h_state1)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int k = 0;        // clks since reset release, sampled on negedge

    // Reference model: position during clk k after release with divide d.
    function automatic int m_pos(input int kk, input int d);
        return ((kk - 1) / d) % 800;
    endfunction

    // Expected {pix_en, h_sync, h_active, h_col, h_count, line_end, state}.
    function automatic logic [25:0] m_vec(input int kk, input int d, input logic pol);
        int p;
        logic pe, sy, act, le;
        logic [9:0] col, cnt;
        logic [1:0] st;
        p   = m_pos(kk, d);
        pe  = ((kk % d) == 0);
        sy  = (p >= 656 && p <= 751) ? pol : ~pol;
        act = (p < 640);
        cnt = 10'(p);
        col = act ? cnt : 10'd0;
        le  = pe && (p == 799);
        st  = (p < 640) ? 2'd0 : (p < 656) ? 2'd1 : (p < 752) ? 2'd2 : 2'd3;
        return {pe, sy, act, col, cnt, le, st};
    endfunction

    logic [25:0] v0, v1;
    assign v0 = {pix_en0, h_sync0, h_active0, h_col0, h_count0, line_end0, h_state0};
    assign v1 = {pix_en1, h_sync1, h_active1, h_col1, h_count1, line_end1, h_state1};

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        k = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (h_sync0 !== 1'b1) begin errors++; $display("FAIL reset_h_sync got=%b exp=1", h_sync0); end
        checks++; if (h_count0 !== 10'd0) begin errors++; $display("FAIL reset_h_count got=%0d exp=0", h_count0); end
        checks++; if (pix_en0 !== 1'b0) begin errors++; $display("FAIL reset_pix_en got=%b exp=0", pix_en0); end
        checks++; if (line_end0 !== 1'b0) begin errors++; $display("FAIL reset_line_end got=%b exp=0", line_end0); end
        checks++; if (h_active0 !== 1'b1) begin errors++; $display("FAIL reset_h_active got=%b exp=1", h_active0); end
        checks++; if (h_col0 !== 10'd0) begin errors++; $display("FAIL reset_h_col got=%0d exp=0", h_col0); end
        checks++; if (h_sync1 !== 1'b0) begin errors++; $display("FAIL reset_h_sync_pol1 got=%b exp=0", h_sync1); end
        reset = 1'b1;
        k = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (pix_en0 !== (k == 4)) begin
                errors++; $display("FAIL first_pix_en k=%0d got=%b exp=%b", k, pix_en0, (k == 4));
            end
        end
        checks++; if (h_count0 !== 10'd0) begin errors++; $display("FAIL first_strobe_h_count got=%0d exp=0", h_count0); end
        checks++; if (h_active0 !== 1'b1) begin errors++; $display("FAIL first_strobe_h_active got=%b exp=1", h_active0); end
    endtask

    task automatic test_strobe_period();
        int hi_cnt, last_k;
        hi_cnt = 0;
        last_k = 4;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (v0 !== m_vec(k, 4, 1'b0)) begin
                errors++; $display("FAIL strobe_model k=%0d got=%h exp=%h", k, v0, m_vec(k, 4, 1'b0));
            end
            if (pix_en0) begin
                hi_cnt++;
                checks++;
                if (k - last_k !== 4) begin
                    errors++; $display("FAIL strobe_spacing k=%0d got=%0d exp=4", k, k - last_k);
                end
                last_k = k;
            end
        end
        checks++;
        if (hi_cnt !== 10) begin errors++; $display("FAIL strobe_count got=%0d exp=10", hi_cnt); end
    endtask

    task automatic test_full_line();
        int act_ok, sync_cnt, sync_first, sync_last, le_cnt, le_k;
        logic [9:0] le_cnt_val;
        act_ok = 0; sync_cnt = 0; sync_first = -1; sync_last = -1;
        le_cnt = 0; le_k = -1; le_cnt_val = '0;
        do_reset();
        while (k < 3204) begin
            tick();
            checks++;
            if (v0 !== m_vec(k, 4, 1'b0)) begin
                errors++;
                if (errors < 30) $display("FAIL line_model k=%0d got=%h exp=%h", k, v0, m_vec(k, 4, 1'b0));
            end
            if (pix_en0 && k <= 3200) begin
                if (h_active0 && h_col0 == h_count0 && h_count0 < 10'd640) act_ok++;
                if (h_sync0 == 1'b0) begin
                    sync_cnt++;
                    if (sync_first < 0) sync_first = int'(h_count0);
                    sync_last = int'(h_count0);
                end
                if (line_end0) begin
                    le_cnt++; le_k = k; le_cnt_val = h_count0;
                end
            end
        end
        checks++; if (act_ok !== 640) begin errors++; $display("FAIL active_strobes got=%0d exp=640", act_ok); end
        checks++; if (sync_cnt !== 96) begin errors++; $display("FAIL sync_strobes got=%0d exp=96", sync_cnt); end
        checks++; if (sync_first !== 656) begin errors++; $display("FAIL sync_first got=%0d exp=656", sync_first); end
        checks++; if (sync_last !== 751) begin errors++; $display("FAIL sync_last got=%0d exp=751", sync_last); end
        checks++; if (le_cnt !== 1) begin errors++; $display("FAIL line_end_count got=%0d exp=1", le_cnt); end
        checks++; if (le_k !== 3200) begin errors++; $display("FAIL line_len_clks got=%0d exp=3200", le_k); end
        checks++; if (le_cnt_val !== 10'd799) begin errors++; $display("FAIL line_end_h_count got=%0d exp=799", le_cnt_val); end
        // k == 3204: first strobe of the next line
        checks++;
        if (!(pix_en0 === 1'b1 && h_count0 === 10'd0)) begin
            errors++; $display("FAIL next_line_start got=%b/%0d exp=1/0", pix_en0, h_count0);
        end
    endtask

    task automatic test_multi_line();
        int le_n, fe_n, last_le, last_fe;
        logic prev_sync;
        le_n = 0; fe_n = 0; last_le = 3200; last_fe = -1;
        prev_sync = h_sync0;
        while (k < 12804) begin
            tick();
            checks++;
            if (v0 !== m_vec(k, 4, 1'b0)) begin
                errors++;
                if (errors < 30) $display("FAIL multi_model k=%0d got=%h exp=%h", k, v0, m_vec(k, 4, 1'b0));
            end
            if (line_end0) begin
                le_n++;
                checks++;
                if (k - last_le !== 3200) begin
                    errors++; $display("FAIL line_end_spacing k=%0d got=%0d exp=3200", k, k - last_le);
                end
                last_le = k;
            end
            if (prev_sync === 1'b1 && h_sync0 === 1'b0) begin
                fe_n++;
                if (last_fe >= 0) begin
                    checks++;
                    if (k - last_fe !== 3200) begin
                        errors++; $display("FAIL sync_fall_spacing k=%0d got=%0d exp=3200", k, k - last_fe);
                    end
                end
                last_fe = k;
            end
            prev_sync = h_sync0;
        end
        checks++; if (le_n !== 3) begin errors++; $display("FAIL multi_line_end_count got=%0d exp=3", le_n); end
        checks++; if (fe_n !== 3) begin errors++; $display("FAIL sync_fall_count got=%0d exp=3", fe_n); end
    endtask

    task automatic test_mid_reset();
        int early_le;
        early_le = 0;
        do_reset();
        while (!(pix_en0 === 1'b1 && h_count0 === 10'd700) && k < 4000) tick();
        checks++; if (k !== 2804) begin errors++; $display("FAIL reach_700 got=%0d exp=2804", k); end
        checks++; if (h_sync0 !== 1'b0) begin errors++; $display("FAIL sync_at_700 got=%b exp=0", h_sync0); end
        #2 reset = 1'b0;
        #1;
        checks++; if (h_sync0 !== 1'b1) begin errors++; $display("FAIL async_h_sync got=%b exp=1", h_sync0); end
        checks++; if (h_count0 !== 10'd0) begin errors++; $display("FAIL async_h_count got=%0d exp=0", h_count0); end
        checks++; if (h_state0 !== 2'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", h_state0); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        k = 0;
        while (k < 3200) begin
            tick();
            checks++;
            if (v0 !== m_vec(k, 4, 1'b0)) begin
                errors++;
                if (errors < 30) $display("FAIL restart_model k=%0d got=%h exp=%h", k, v0, m_vec(k, 4, 1'b0));
            end
            if (line_end0 && k < 3200) early_le++;
        end
        checks++; if (early_le !== 0) begin errors++; $display("FAIL partial_line_end got=%0d exp=0", early_le); end
        checks++; if (line_end0 !== 1'b1) begin errors++; $display("FAIL restart_line_end got=%b exp=1", line_end0); end
    endtask

    task automatic test_config_div1();
        int pe_n, sync_hi, le_k;
        pe_n = 0; sync_hi = 0; le_k = -1;
        do_reset();
        while (k < 804) begin
            tick();
            checks++;
            if (v1 !== m_vec(k, 1, 1'b1)) begin
                errors++;
                if (errors < 30) $display("FAIL div1_model k=%0d got=%h exp=%h", k, v1, m_vec(k, 1, 1'b1));
            end
            if (pix_en1) pe_n++;
            if (h_sync1 && k <= 800) sync_hi++;
            if (line_end1 && le_k < 0) le_k = k;
        end
        checks++; if (pe_n !== 804) begin errors++; $display("FAIL div1_pix_en got=%0d exp=804", pe_n); end
        checks++; if (sync_hi !== 96) begin errors++; $display("FAIL div1_sync_high got=%0d exp=96", sync_hi); end
        checks++; if (le_k !== 800) begin errors++; $display("FAIL div1_line_len got=%0d exp=800", le_k); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_strobe_period();
        test_full_line();
        test_multi_line();
        test_mid_reset();
        test_config_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
